// File: rtl/keccak_x_heep_pkg.sv
// Register map, bit positions and shared types for the Keccak OBI responder.
package keccak_x_heep_pkg;

    localparam int DATA_W    = 32;
    localparam int STATE_W   = 1600;
    localparam int NUM_WORDS = STATE_W / DATA_W;

    // Word offsets, taken from addr[8:2].
    localparam int OFS_W = 7;
    localparam logic [OFS_W-1:0] KECCAK_DIN_OFS = 7'd0;
    localparam logic [OFS_W-1:0] CTRL_OFS       = 7'd50;
    localparam logic [OFS_W-1:0] STATUS_OFS     = 7'd51;
    localparam logic [OFS_W-1:0] INTR_EN_OFS    = 7'd52;
    localparam logic [OFS_W-1:0] DOUT_OFS       = 7'd64;

    // Bit positions inside the control/status words.
    localparam int CTRL_START_BIT  = 0;
    localparam int STATUS_DONE_BIT = 0;
    localparam int STATUS_BUSY_BIT = 1;
    localparam int INTR_EN_BIT     = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ctrl_state_e;

    // Merge new_w into old_w on the byte lanes enabled in be.
    function automatic logic [DATA_W-1:0] apply_be(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [3:0]        be);
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by every responder on the bus.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/keccak_obi_ctrl_fsm.sv
// Run control for the Keccak core: IDLE/BUSY state, start pulse, sticky DONE
// and the completion interrupt.
module keccak_obi_ctrl_fsm
    import keccak_x_heep_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_req_i,  // CTRL write with START=1 this cycle
    input  logic        done_i,       // core completion pulse
    input  logic        done_clr_i,   // STATUS write with DONE=1 (W1C)
    input  logic        intr_en_i,
    output logic        start_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        intr_o,
    output logic        capture_o,    // latch the core output this cycle
    output ctrl_state_e state_o
);

    ctrl_state_e state_q, state_d;
    logic        start_q, start_d;
    logic        done_q, done_d;

    // State register; reset drops BUSY, DONE and any pending pulse at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    // Next state: completion is judged on the current state, so a START that
    // coincides with done sees BUSY and is dropped; a done that coincides with
    // the W1C wins and leaves DONE set.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (start_req_i) begin
                    state_d = ST_BUSY;
                    start_d = 1'b1;
                    done_d  = 1'b0;
                end else if (done_clr_i) begin
                    done_d = 1'b0;
                end
            end
            ST_BUSY: begin
                if (done_i) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (done_clr_i) begin
                    done_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: everything except capture comes straight from flops.
    always_comb begin
        start_o   = start_q;
        busy_o    = (state_q == ST_BUSY);
        done_o    = done_q;
        intr_o    = done_q & intr_en_i;
        capture_o = done_i & (state_q == ST_BUSY);
        state_o   = state_q;
    end

endmodule

// File: rtl/keccak_obi_slave.sv
// OBI responder wrapping the Keccak permutation: fifty DIN words, control and
// status registers, interrupt enable and fifty captured DOUT words.
//
// Handshake: gnt follows req combinationally, so every request is accepted in
// the cycle it is presented; exactly one cycle later rvalid is high for one
// cycle with registered rdata (0 for writes). One transaction per cycle.
module keccak_obi_slave
    import obi_pkg::*;
    import keccak_x_heep_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  obi_req_t           obi_req_i,
    output obi_resp_t          obi_resp_o,
    output logic [STATE_W-1:0] keccak_din_o,
    output logic               keccak_start_o,
    input  logic [STATE_W-1:0] keccak_dout_i,
    input  logic               keccak_done_i,
    output logic               intr_o
);

    logic [DATA_W-1:0] din_q  [NUM_WORDS];
    logic [DATA_W-1:0] din_d  [NUM_WORDS];
    logic [DATA_W-1:0] dout_q [NUM_WORDS];
    logic [DATA_W-1:0] dout_d [NUM_WORDS];
    logic              intr_en_q, intr_en_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [OFS_W-1:0]  ofs;
    logic              wr_en;
    logic              is_din, is_dout;
    logic              start_req, done_clr;
    logic              busy, done, capture;
    ctrl_state_e       fsm_state;
    logic [DATA_W-1:0] rd_word;
    logic              unused_addr_bits;

    assign ofs              = obi_req_i.addr[8:2];
    assign unused_addr_bits = ^{obi_req_i.addr[31:9], obi_req_i.addr[1:0]};
    assign wr_en            = obi_req_i.req & obi_req_i.we;
    assign is_din           = (ofs < KECCAK_DIN_OFS + 7'(NUM_WORDS));
    assign is_dout          = (ofs >= DOUT_OFS) && (ofs < DOUT_OFS + 7'(NUM_WORDS));

    assign start_req = wr_en && (ofs == CTRL_OFS) && obi_req_i.be[0]
                       && obi_req_i.wdata[CTRL_START_BIT];
    assign done_clr  = wr_en && (ofs == STATUS_OFS) && obi_req_i.be[0]
                       && obi_req_i.wdata[STATUS_DONE_BIT];

    keccak_obi_ctrl_fsm u_ctrl_fsm (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_req_i (start_req),
        .done_i      (keccak_done_i),
        .done_clr_i  (done_clr),
        .intr_en_i   (intr_en_q),
        .start_o     (keccak_start_o),
        .busy_o      (busy),
        .done_o      (done),
        .intr_o      (intr_o),
        .capture_o   (capture),
        .state_o     (fsm_state)
    );

    // Word k of the input state occupies bits [32k+31:32k].
    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_din_out
        assign keccak_din_o[k*DATA_W +: DATA_W] = din_q[k];
    end

    // Register-file updates: DIN frozen while the core runs, INTR_EN, DOUT capture.
    always_comb begin
        din_d     = din_q;
        dout_d    = dout_q;
        intr_en_d = intr_en_q;
        if (wr_en && is_din && (fsm_state == ST_IDLE)) begin
            din_d[ofs[5:0]] = apply_be(din_q[ofs[5:0]], obi_req_i.wdata, obi_req_i.be);
        end
        if (wr_en && (ofs == INTR_EN_OFS) && obi_req_i.be[0]) begin
            intr_en_d = obi_req_i.wdata[INTR_EN_BIT];
        end
        if (capture) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                dout_d[k] = keccak_dout_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Read decode; CTRL and unmapped offsets read as zero.
    always_comb begin
        rd_word = '0;
        if (is_din) begin
            rd_word = din_q[ofs[5:0]];
        end else if (ofs == STATUS_OFS) begin
            rd_word[STATUS_DONE_BIT] = done;
            rd_word[STATUS_BUSY_BIT] = busy;
        end else if (ofs == INTR_EN_OFS) begin
            rd_word[INTR_EN_BIT] = intr_en_q;
        end else if (is_dout) begin
            rd_word = dout_q[ofs[5:0]];
        end
    end

    // Response for the request accepted this cycle, presented next cycle.
    always_comb begin
        rvalid_d = obi_req_i.req;
        rdata_d  = '0;
        if (obi_req_i.req && !obi_req_i.we) begin
            rdata_d = rd_word;
        end
    end

    // Storage and response flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                din_q[k]  <= '0;
                dout_q[k] <= '0;
            end
            intr_en_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                din_q[k]  <= din_d[k];
                dout_q[k] <= dout_d[k];
            end
            intr_en_q <= intr_en_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    // Bus response assembly.
    always_comb begin
        obi_resp_o.gnt    = obi_req_i.req;
        obi_resp_o.rvalid = rvalid_q;
        obi_resp_o.rdata  = rdata_q;
    end

endmodule

// File: tb/tb_keccak_obi_slave.sv
// Directed bench for keccak_obi_slave with a response scoreboard.
module tb_keccak_obi_slave;
    import obi_pkg::*;

    localparam int SW = 1600;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    obi_req_t      obi_req;
    obi_resp_t     obi_resp;
    logic [SW-1:0] din_o;
    logic [SW-1:0] dout_i;
    logic          start_o;
    logic          done_i;
    logic          intr;

    keccak_obi_slave dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .obi_req_i      (obi_req),
        .obi_resp_o     (obi_resp),
        .keccak_din_o   (din_o),
        .keccak_start_o (start_o),
        .keccak_dout_i  (dout_i),
        .keccak_done_i  (done_i),
        .intr_o         (intr)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic        req_d1      = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // A response is due exactly one cycle after each request the bench drove.
    always @(posedge clk or posedge rst) begin
        if (rst) req_d1 <= 1'b0;
        else     req_d1 <= obi_req.req;
    end

    always @(negedge clk) begin
        check("rvalid", 32'(obi_resp.rvalid), 32'(req_d1));
        if (obi_resp.rvalid) begin
            check("resp_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("rdata", obi_resp.rdata, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] wa(input int ofs);
        return 32'(ofs * 4);
    endfunction

    task automatic drive(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata);
        obi_req.req   = 1'b1;
        obi_req.we    = we;
        obi_req.be    = be;
        obi_req.addr  = addr;
        obi_req.wdata = wdata;
    endtask

    task automatic idle();
        obi_req = '0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] be);
        @(negedge clk);
        drive(addr, 1'b1, be, data);
        #1 check("gnt_wr", 32'(obi_resp.gnt), 32'd1);
        exp_q.push_back(32'h0);
        @(posedge clk);
        #1 idle();
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        drive(addr, 1'b0, 4'hF, 32'h0);
        #1 check("gnt_rd", 32'(obi_resp.gnt), 32'd1);
        exp_q.push_back(exp);
        @(posedge clk);
        #1 idle();
    endtask

    task automatic set_dout(input logic [31:0] w0, input logic [31:0] w49);
        dout_i           = '0;
        dout_i[31:0]     = w0;
        dout_i[1599:1568] = w49;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        done_i = 1'b1;
        @(posedge clk);
        #1 done_i = 1'b0;
    endtask

    // done and a register write presented in the same cycle
    task automatic done_with_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        done_i = 1'b1;
        drive(addr, 1'b1, 4'hF, data);
        #1 exp_q.push_back(32'h0);
        @(posedge clk);
        #1 begin
            done_i = 1'b0;
            idle();
        end
    endtask

    // START accepted: pulse in the next cycle only
    task automatic expect_start_pulse(input string tag);
        @(negedge clk);
        check({tag, "_hi"}, 32'(start_o), 32'd1);
        @(negedge clk);
        check({tag, "_lo"}, 32'(start_o), 32'd0);
    endtask

    task automatic expect_no_start(input string tag);
        @(negedge clk);
        check(tag, 32'(start_o), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        obi_req = '0;
        done_i  = 1'b0;
        dout_i  = '0;

        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(obi_resp.gnt), 32'd0);
        check("rst_rvalid", 32'(obi_resp.rvalid), 32'd0);
        check("rst_rdata", obi_resp.rdata, 32'h0);
        check("rst_start", 32'(start_o), 32'd0);
        check("rst_intr", 32'(intr), 32'd0);
        check("rst_din0", din_o[31:0], 32'h0);
        rst = 1'b0;

        // byte-lane write to DIN[0]
        bus_write(wa(0), 32'hDEADBEEF, 4'b0011);
        check("din_o_w0", din_o[31:0], 32'h0000BEEF);
        bus_read(wa(0), 32'h0000BEEF);
        bus_write(wa(1), 32'hFFFFFFFF, 4'b0000);
        bus_read(wa(1), 32'h0);
        bus_write(wa(3), 32'hA5A5A5A5, 4'b1111);
        check("din_o_w3", din_o[127:96], 32'hA5A5A5A5);
        bus_write(wa(49), 32'h0F0F1234, 4'b1100);
        bus_read(wa(49), 32'h0F0F0000);
        check("din_o_w49", din_o[1599:1568], 32'h0F0F0000);

        // interrupt enable
        bus_write(wa(52), 32'h1, 4'b0001);
        bus_read(wa(52), 32'h1);

        // start from idle
        bus_write(wa(50), 32'h1, 4'b0001);
        expect_start_pulse("start1");
        bus_read(wa(51), 32'h2);
        bus_read(wa(50), 32'h0);

        // writes while busy: no restart, DIN frozen
        bus_write(wa(50), 32'h1, 4'b0001);
        expect_no_start("start_busy");
        bus_write(wa(3), 32'hFFFFFFFF, 4'b1111);
        bus_read(wa(3), 32'hA5A5A5A5);
        check("din_o_frozen", din_o[127:96], 32'hA5A5A5A5);

        // completion captures the core output
        set_dout(32'h12345678, 32'hCAFEF00D);
        pulse_done();
        check("intr_set", 32'(intr), 32'd1);
        bus_read(wa(51), 32'h1);
        bus_read(wa(64), 32'h12345678);
        bus_read(wa(113), 32'hCAFEF00D);

        // W1C clears DONE and the interrupt
        bus_write(wa(51), 32'h1, 4'b0001);
        check("intr_clr", 32'(intr), 32'd0);
        bus_read(wa(51), 32'h0);

        // done and W1C in the same cycle: DONE stays set
        bus_write(wa(50), 32'h1, 4'b0001);
        expect_start_pulse("start2");
        set_dout(32'h0BADF00D, 32'h0);
        done_with_write(wa(51), 32'h1);
        bus_read(wa(51), 32'h1);
        check("intr_w1c_race", 32'(intr), 32'd1);

        // done and START in the same cycle: completion wins, no pulse
        bus_write(wa(50), 32'h1, 4'b0001);
        expect_start_pulse("start3");
        set_dout(32'h600DCAFE, 32'h0);
        done_with_write(wa(50), 32'h1);
        expect_no_start("start_race");
        bus_read(wa(51), 32'h1);
        bus_read(wa(64), 32'h600DCAFE);

        // done while idle is ignored
        set_dout(32'h55555555, 32'h55555555);
        pulse_done();
        bus_read(wa(64), 32'h600DCAFE);
        bus_read(wa(113), 32'h0);

        // back-to-back reads: unmapped/CTRL byte address 200, then INTR_EN
        @(negedge clk);
        drive(32'd200, 1'b0, 4'hF, 32'h0);
        #1 exp_q.push_back(32'h0);
        @(posedge clk);
        #1 drive(wa(52), 1'b0, 4'hF, 32'h0);
        exp_q.push_back(32'h1);
        @(posedge clk);
        #1 idle();
        bus_read(wa(90) | 32'hFFFF_FE00, 32'h0);
        bus_write(wa(60), 32'hFFFFFFFF, 4'hF);
        bus_read(wa(60), 32'h0);

        // reset during the start pulse
        bus_write(wa(50), 32'h1, 4'b0001);
        @(negedge clk);
        check("start4_hi", 32'(start_o), 32'd1);
        #1 rst = 1'b1;
        #1 begin
            check("rst_mid_start", 32'(start_o), 32'd0);
            check("rst_mid_intr", 32'(intr), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus_read(wa(51), 32'h0);
        bus_read(wa(52), 32'h0);
        bus_read(wa(0), 32'h0);
        set_dout(32'h11111111, 32'h11111111);
        pulse_done();
        check("intr_after_rst", 32'(intr), 32'd0);
        bus_read(wa(51), 32'h0);
        bus_read(wa(64), 32'h0);

        repeat (3) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
